// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: packs a valid/ready byte stream
// little-endian into 32-bit words and issues one write per word from address 0.
module imem_loader #(
  parameter int N      = 32,
  parameter int LENGTH = 512,
  parameter int WIDTH  = 9
) (
  input  logic           clk,
  input  logic           rstb,
  input  logic           start,
  input  logic [WIDTH:0] num_words,
  input  logic           abort,
  input  logic [7:0]     byte_in,
  input  logic           byte_valid,
  output logic           byte_ready,
  output logic           mem_we,
  output logic [N-1:0]   mem_addr,
  output logic [N-1:0]   mem_wdata,
  output logic           busy,
  output logic           done,
  output logic           error
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_e;

  localparam logic [WIDTH:0] MAX_WORDS = (WIDTH+1)'(LENGTH);
  localparam logic [WIDTH:0] ONE       = (WIDTH+1)'(1);

  state_e             state_q, state_d;
  logic [1:0]         byte_idx_q;
  logic [WIDTH-1:0]   word_idx_q;
  logic [WIDTH:0]     count_q;
  logic [N-9:0]       word_q;      // bytes 0..2 of the word being assembled
  logic [N-1:0]       addr_q;
  logic [N-1:0]       wdata_q;
  logic               error_q;
  logic               accept;
  logic               last_word;

  assign accept    = (state_q == S_FILL) && byte_valid && !abort;
  assign last_word = ({1'b0, word_idx_q} == (count_q - ONE));

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; abort wins over everything, including start in IDLE.
  // NOTE: state_d gets a default first so no path leaves it unassigned, which
  // would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start && (num_words <= MAX_WORDS))
                   state_d = (num_words == '0) ? S_DONE : S_FILL;
        S_FILL:  if (accept && (byte_idx_q == 2'd3)) state_d = S_WRITE;
        S_WRITE: state_d = last_word ? S_DONE : S_FILL;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath: count/index bookkeeping, byte packing and the held write port.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      byte_idx_q <= '0;
      word_idx_q <= '0;
      count_q    <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            if (num_words > MAX_WORDS) begin
              error_q <= 1'b1;
            end else begin
              error_q    <= 1'b0;
              count_q    <= num_words;
              word_idx_q <= '0;
              byte_idx_q <= '0;
            end
          end
        end
        S_FILL: begin
          if (accept) begin
            byte_idx_q <= byte_idx_q + 2'd1;
            case (byte_idx_q)
              2'd0: word_q[7:0]   <= byte_in;
              2'd1: word_q[15:8]  <= byte_in;
              2'd2: word_q[23:16] <= byte_in;
              default: begin
                addr_q  <= {{(N-WIDTH-2){1'b0}}, word_idx_q, 2'b00};
                wdata_q <= {byte_in, word_q};
              end
            endcase
          end
        end
        S_WRITE: begin
          if (!abort && !last_word) word_idx_q <= word_idx_q + WIDTH'(1);
        end
        default: ;
      endcase
      if (abort) byte_idx_q <= '0;
    end
  end

  // Output decode
  always_comb begin
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_FILL:  begin byte_ready = 1'b1; busy = 1'b1; end
      S_WRITE: begin mem_we = !abort;  busy = 1'b1; end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as words are
// driven and popped by a monitor on each mem_we.
module tb_imem_loader;

  localparam int N      = 32;
  localparam int LENGTH = 512;
  localparam int WIDTH  = 9;

  logic           clk = 1'b0;
  logic           rstb;
  logic           start;
  logic [WIDTH:0] num_words;
  logic           abort;
  logic [7:0]     byte_in;
  logic           byte_valid;
  logic           byte_ready;
  logic           mem_we;
  logic [N-1:0]   mem_addr;
  logic [N-1:0]   mem_wdata;
  logic           busy;
  logic           done;
  logic           error;

  imem_loader #(.N(N), .LENGTH(LENGTH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rstb       (rstb),
    .start      (start),
    .num_words  (num_words),
    .abort      (abort),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         sb_q[$];
  wr_t         exp_wr;
  logic [7:0]  stream [0:4*LENGTH-1];
  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          last_we_cyc = 0;
  logic [31:0] last_addr   = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest queued word.
  always @(negedge clk) begin
    if (rstb && mem_we) begin
      check("ready_in_write", 64'(byte_ready), 64'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_write", 64'(mem_addr), 64'hFFFF_FFFF);
      end else begin
        exp_wr = sb_q.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(exp_wr.addr));
        check("wr_data", 64'(mem_wdata), 64'(exp_wr.data));
      end
      last_we_cyc = cyc;
      last_addr   = mem_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit taken = 1'b0;
    byte_valid = 1'b0;
    repeat (gap) tick();
    byte_in    = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 50 && !taken; i++) begin
      if (byte_ready) taken = 1'b1;
      tick();
    end
    if (!taken) check("byte_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_word(input int idx, input int gap);
    wr_t w;
    w.addr = 32'(idx * 4);
    w.data = {stream[4*idx+3], stream[4*idx+2], stream[4*idx+1], stream[4*idx]};
    sb_q.push_back(w);
    for (int b = 0; b < 4; b++) send_byte(stream[4*idx+b], gap);
  endtask

  task automatic start_load(input int n);
    num_words = (WIDTH+1)'(n);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit found = 1'b0;
    byte_valid = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    check({tag, "_done_seen"}, 64'(found), 64'd1);
    if (found) check({tag, "_done_lat"}, 64'(cyc - last_we_cyc), 64'd1);
    tick();
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
  endtask

  task automatic do_load(input string tag, input int n, input int gap);
    start_load(n);
    for (int w = 0; w < n; w++) send_word(w, gap);
    wait_done(tag);
  endtask

  task automatic set_base_stream();
    logic [7:0] base [0:7];
    base = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    for (int i = 0; i < 8; i++) stream[i] = base[i];
  endtask

  initial begin
    rstb = 1'b0; start = 1'b0; abort = 1'b0; num_words = '0;
    byte_in = '0; byte_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", 64'({byte_ready, mem_we, busy, done, error}), 64'd0);
    check("reset_addr", 64'(mem_addr), 64'd0);
    check("reset_wdata", 64'(mem_wdata), 64'd0);
    rstb = 1'b1;
    tick();

    // Two words, valid held high
    set_base_stream();
    do_load("t2", 2, 0);
    check("t2_hold_addr", 64'(mem_addr), 64'h4);
    check("t2_hold_data", 64'(mem_wdata), 64'hDEAD_BEEF);

    // Same stream with valid toggling
    do_load("t3", 2, 1);

    // Zero-length and oversize loads
    start_load(0);
    check("t4_zero_done", 64'(done), 64'd1);
    check("t4_zero_busy", 64'(busy), 64'd0);
    tick();
    check("t4_zero_pulse", 64'(done), 64'd0);
    start_load(513);
    check("t4_err_set", 64'(error), 64'd1);
    for (int i = 0; i < 3; i++) begin
      check("t4_err_busy", 64'(busy), 64'd0);
      tick();
    end
    check("t4_err_sticky", 64'(error), 64'd1);
    start_load(1);
    check("t4_err_clr", 64'(error), 64'd0);
    send_word(0, 0);
    wait_done("t4_after");

    // Abort mid-word, start ignored in FILL, abort beats start in IDLE
    start_load(2);
    send_word(0, 0);
    send_byte(stream[4], 0);
    send_byte(stream[5], 0);
    byte_valid = 1'b0;
    num_words = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t5_start_ign_busy", 64'(busy), 64'd1);
    check("t5_start_ign_done", 64'(done), 64'd0);
    abort = 1'b1;
    tick();
    check("t5_abort_busy", 64'(busy), 64'd0);
    check("t5_abort_ready", 64'(byte_ready), 64'd0);
    num_words = (WIDTH+1)'(513);
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("t5_abort_err", 64'(error), 64'd0);
    check("t5_abort_idle", 64'({busy, done}), 64'd0);
    repeat (3) tick();
    check("t5_sb_empty", 64'(sb_q.size()), 64'd0);
    stream[0] = 8'h11; stream[1] = 8'h22; stream[2] = 8'h33; stream[3] = 8'h44;
    do_load("t5_after", 1, 0);

    // Reset mid-FILL
    set_base_stream();
    stream[8] = 8'hAA; stream[9] = 8'hBB;
    start_load(3);
    send_word(0, 0);
    send_word(1, 0);
    send_byte(stream[8], 0);
    send_byte(stream[9], 0);
    byte_valid = 1'b0;
    rstb = 1'b0;
    #1;
    check("t1_rst_ctrl", 64'({byte_ready, mem_we, busy, done, error}), 64'd0);
    check("t1_rst_addr", 64'(mem_addr), 64'd0);
    check("t1_rst_data", 64'(mem_wdata), 64'd0);
    tick();
    rstb = 1'b1;
    tick();
    check("t1_sb_empty", 64'(sb_q.size()), 64'd0);
    do_load("t1_after", 1, 0);

    // Full-depth load
    for (int i = 0; i < 4*LENGTH; i++) stream[i] = 8'(i);
    do_load("t6", LENGTH, 0);
    check("t6_last_addr", 64'(last_addr), 64'h7FC);
    repeat (3) tick();
    check("t6_no_extra", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
